// File: rtl/wb_bus_splitter_reg.sv
// Registered Wishbone B4 classic 1-to-N splitter with an IDLE/ACTIVE/RESP FSM.
// Optional slave-silence timeout is compiled in when WB_SPLIT_TIMEOUT_EN is defined.
module wb_bus_splitter_reg #(
    parameter int NUM_PERIPHERALS  = 4,
    parameter int ADDR_WIDTH       = 32,
    parameter int DATA_WIDTH       = 32,
    parameter int SEL_WIDTH        = 4,
    parameter int ADDR_SEL_LOW_BIT = 16,
    parameter int IDX_W            = 4,
    parameter int TIMEOUT_CYCLES   = 255
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [ADDR_WIDTH-1:0]                 m_wb_adr_i,
    input  logic [DATA_WIDTH-1:0]                 m_wb_dat_i,
    input  logic [SEL_WIDTH-1:0]                  m_wb_sel_i,
    input  logic                                  m_wb_we_i,
    input  logic                                  m_wb_cyc_i,
    input  logic                                  m_wb_stb_i,
    output logic [DATA_WIDTH-1:0]                 m_wb_dat_o,
    output logic                                  m_wb_ack_o,
    output logic                                  m_wb_err_o,
    output logic [NUM_PERIPHERALS-1:0]            s_wb_cyc_o,
    output logic [NUM_PERIPHERALS-1:0]            s_wb_stb_o,
    output logic [NUM_PERIPHERALS-1:0]            s_wb_we_o,
    output logic [NUM_PERIPHERALS*SEL_WIDTH-1:0]  s_wb_sel_o,
    output logic [NUM_PERIPHERALS*ADDR_WIDTH-1:0] s_wb_adr_o,
    output logic [NUM_PERIPHERALS*DATA_WIDTH-1:0] s_wb_dat_o,
    input  logic [NUM_PERIPHERALS*DATA_WIDTH-1:0] s_wb_dat_i,
    input  logic [NUM_PERIPHERALS-1:0]            s_wb_ack_i,
    input  logic [NUM_PERIPHERALS-1:0]            s_wb_err_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [IDX_W:0] NUM_P = (IDX_W+1)'(NUM_PERIPHERALS);

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       slaveIdx_q, slaveIdx_d;
    logic [ADDR_WIDTH-1:0]  adr_q, adr_d;
    logic [DATA_WIDTH-1:0]  wrDat_q, wrDat_d;
    logic [SEL_WIDTH-1:0]   sel_q, sel_d;
    logic                   we_q, we_d;
    logic                   rspAck_q, rspAck_d;
    logic                   rspErr_q, rspErr_d;
    logic [DATA_WIDTH-1:0]  rdBuf_q, rdBuf_d;
    logic [DATA_WIDTH-1:0]  mDat_q, mDat_d;
    logic                   mAck_q, mAck_d;
    logic                   mErr_q, mErr_d;

    logic [IDX_W-1:0]            reqIdx;
    logic                        reqMapped;
    logic                        reqValid;
    logic                        pulseBusy;
    logic [NUM_PERIPHERALS-1:0]  slaveSel;
    logic                        selAck;
    logic                        selErr;
    logic [DATA_WIDTH-1:0]       selDat;
    logic                        timeoutHit;

    assign reqIdx    = m_wb_adr_i[ADDR_SEL_LOW_BIT +: IDX_W];
    assign reqMapped = ({1'b0, reqIdx} < NUM_P);
    assign reqValid  = m_wb_cyc_i & m_wb_stb_i;
    // A classic master still holds stb while our ack/err pulse is visible; that cycle must not start a new transfer.
    assign pulseBusy = mAck_q | mErr_q;

    always_comb begin
        slaveSel = '0;
        for (int k = 0; k < NUM_PERIPHERALS; k++) begin
            slaveSel[k] = (slaveIdx_q == IDX_W'(k));
        end
    end

    assign selAck = |(s_wb_ack_i & slaveSel);
    assign selErr = |(s_wb_err_i & slaveSel);

    always_comb begin
        selDat = '0;
        for (int k = 0; k < NUM_PERIPHERALS; k++) begin
            if (slaveSel[k]) begin
                selDat = selDat | s_wb_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef WB_SPLIT_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] toCnt_q, toCnt_d;

    // Counter holds (ACTIVE cycle number - 1), so it hits TO_LAST during ACTIVE cycle TIMEOUT_CYCLES.
    always_comb begin
        toCnt_d = '0;
        if (state_q == ACTIVE) begin
            toCnt_d = toCnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toCnt_q <= '0;
        end else begin
            toCnt_q <= toCnt_d;
        end
    end

    assign timeoutHit = (toCnt_q == TO_LAST);
`else
    assign timeoutHit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        slaveIdx_d = slaveIdx_q;
        adr_d      = adr_q;
        wrDat_d    = wrDat_q;
        sel_d      = sel_q;
        we_d       = we_q;
        rspAck_d   = rspAck_q;
        rspErr_d   = rspErr_q;
        rdBuf_d    = rdBuf_q;
        mDat_d     = mDat_q;
        mAck_d     = 1'b0;
        mErr_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (reqValid && !pulseBusy) begin
                    rspAck_d = 1'b0;
                    rspErr_d = 1'b0;
                    if (reqMapped) begin
                        slaveIdx_d = reqIdx;
                        adr_d      = m_wb_adr_i;
                        wrDat_d    = m_wb_dat_i;
                        sel_d      = m_wb_sel_i;
                        we_d       = m_wb_we_i;
                        state_d    = ACTIVE;
                    end else begin
                        rspErr_d = 1'b1;
                        state_d  = RESP;
                    end
                end
            end

            ACTIVE: begin
                if (!m_wb_cyc_i) begin
                    state_d = IDLE;
                end else if (selErr) begin
                    rspErr_d = 1'b1;
                    state_d  = RESP;
                end else if (selAck) begin
                    rspAck_d = 1'b1;
                    if (!we_q) begin
                        rdBuf_d = selDat;
                    end
                    state_d = RESP;
                end else if (timeoutHit) begin
                    rspErr_d = 1'b1;
                    state_d  = RESP;
                end
            end

            RESP: begin
                mErr_d = rspErr_q;
                mAck_d = rspAck_q & ~rspErr_q;
                if (rspAck_q && !rspErr_q && !we_q) begin
                    mDat_d = rdBuf_q;
                end
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            slaveIdx_q <= '0;
            adr_q      <= '0;
            wrDat_q    <= '0;
            sel_q      <= '0;
            we_q       <= 1'b0;
            rspAck_q   <= 1'b0;
            rspErr_q   <= 1'b0;
            rdBuf_q    <= '0;
            mDat_q     <= '0;
            mAck_q     <= 1'b0;
            mErr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            slaveIdx_q <= slaveIdx_d;
            adr_q      <= adr_d;
            wrDat_q    <= wrDat_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            rspAck_q   <= rspAck_d;
            rspErr_q   <= rspErr_d;
            rdBuf_q    <= rdBuf_d;
            mDat_q     <= mDat_d;
            mAck_q     <= mAck_d;
            mErr_q     <= mErr_d;
        end
    end

    // Non-selected slaves see the same latched adr/dat/sel; only cyc/stb/we are steered.
    assign s_wb_cyc_o = (state_q == ACTIVE) ? slaveSel : '0;
    assign s_wb_stb_o = (state_q == ACTIVE) ? slaveSel : '0;
    assign s_wb_we_o  = ((state_q == ACTIVE) && we_q) ? slaveSel : '0;
    assign s_wb_adr_o = {NUM_PERIPHERALS{adr_q}};
    assign s_wb_dat_o = {NUM_PERIPHERALS{wrDat_q}};
    assign s_wb_sel_o = {NUM_PERIPHERALS{sel_q}};

    assign m_wb_dat_o = mDat_q;
    assign m_wb_ack_o = mAck_q;
    assign m_wb_err_o = mErr_q;

endmodule
